// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM core pipeline registers.
// Default widths for the MEM->WB boundary and the payload layout it carries.
package arm_pipe_pkg;

   localparam int DATA_W    = 32;
   localparam int REG_IDX_W = 4;

   // Everything the WB stage needs to retire one instruction.
   typedef struct packed {
      logic                 wb_en;
      logic                 mem_r_en;
      logic [DATA_W-1:0]    alu_result;
      logic [DATA_W-1:0]    mem_data;
      logic [REG_IDX_W-1:0] dest;
   } mem_wb_payload_t;

   // Packed payload width for arbitrary data/destination widths, laid out
   // in the same field order as mem_wb_payload_t.
   function automatic int payload_width(input int data_w, input int dest_w);
      return 2 + 2 * data_w + dest_w;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a payload register plus its valid bit.
// Reset zeroes both; flush empties the slot but leaves the payload untouched.
module pipe_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic             valid,
   output logic [WIDTH-1:0] q
);

   // Valid bit: reset beats flush, flush beats load, load beats clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

   // Payload only changes on a load outside flush, so a held entry never moves.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= '0;
      end else if (load && !flush) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// Elastic MEM->WB pipeline boundary with stall, flush and bubble tracking.
// The write-back value is selected here so the WB stage needs no mux.
// Optional feature: define MEM_WB_SKID_EN for a two-entry head+skid stage whose
// in_ready is registered; otherwise a single entry with combinational in_ready.
module mem_wb_pipe_stage #(
   parameter int DATA_W = arm_pipe_pkg::DATA_W,
   parameter int DEST_W = arm_pipe_pkg::REG_IDX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] mem_data_in,
   input  logic [DEST_W-1:0] dest_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              wb_en,
   output logic              mem_r_en,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] data_memory_out,
   output logic [DEST_W-1:0] dest,
   output logic [DATA_W-1:0] wb_value
);

   import arm_pipe_pkg::*;

   localparam int PW = payload_width(DATA_W, DEST_W);

   logic          accept;
   logic          pop;
   logic          head_load;
   logic          head_clear;
   logic [PW-1:0] head_d;
   logic [PW-1:0] head_q;
   logic [PW-1:0] in_pl;
   logic          head_wb_en;

   assign in_pl  = {wb_en_in, mem_r_en_in, alu_result_in, mem_data_in, dest_in};
   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

`ifdef MEM_WB_SKID_EN

   logic          skid_valid;
   logic          skid_load;
   logic          skid_clear;
   logic [PW-1:0] skid_q;

   // Only a registered bit gates intake, so out_ready never reaches in_ready.
   assign in_ready = rst & ~flush & ~skid_valid;

   // Route the incoming entry to head or skid and refill head from skid on pop.
   always_comb begin
      head_load  = 1'b0;
      head_clear = 1'b0;
      head_d     = in_pl;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (pop && skid_valid) begin
         head_load  = 1'b1;
         head_d     = skid_q;
         skid_load  = accept;
         skid_clear = ~accept;
      end else if (accept && (!out_valid || pop)) begin
         head_load = 1'b1;
      end else if (accept) begin
         skid_load = 1'b1;
      end else if (pop) begin
         head_clear = 1'b1;
      end
   end

   pipe_slot #(.WIDTH(PW)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_pl),
      .valid (skid_valid),
      .q     (skid_q)
   );

`else

   // A popping head frees its slot in the same cycle, giving 1/cycle throughput.
   assign in_ready = rst & ~flush & (~out_valid | out_ready);

   // Single slot: accept loads it (replacing a popping head), pop alone empties it.
   always_comb begin
      head_load  = accept;
      head_clear = pop;
      head_d     = in_pl;
   end

`endif

   pipe_slot #(.WIDTH(PW)) u_head (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .load  (head_load),
      .clear (head_clear),
      .d     (head_d),
      .valid (out_valid),
      .q     (head_q)
   );

   assign {head_wb_en, mem_r_en, alu_result, data_memory_out, dest} = head_q;

   // A bubble must never write the register file.
   assign wb_en    = head_wb_en & out_valid;
   assign wb_value = mem_r_en ? data_memory_out : alu_result;

endmodule
